// File: rtl/phys_reg_free_list.sv
// Checkpointed FIFO of unmapped physical register tags.
// Supplies destination tags to rename and takes tags back at commit.
// Revert returns speculative tags to the head. Branch checkpoints
// snapshot the head pointer so that a mispredict can rewind it.
module phys_reg_free_list #(
  parameter int unsigned NUM_PHYS_REGS      = 64,
  parameter int unsigned NUM_ARCH_REGS      = 32,
  parameter int unsigned CHECKPOINT_COLUMNS = 4,
  parameter int unsigned ROB_INDEX_W        = 6,
  localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int unsigned TagW  = $clog2(NUM_PHYS_REGS),
  localparam int unsigned IdxW  = $clog2(DEPTH),
  localparam int unsigned PtrW  = IdxW + 1,
  localparam int unsigned ColW  = $clog2(CHECKPOINT_COLUMNS)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   dequeue_valid,
  output logic                   dequeue_ready,
  output logic [TagW-1:0]        dequeue_phys_reg_tag,
  input  logic                   enqueue_valid,
  input  logic [TagW-1:0]        enqueue_phys_reg_tag,
  input  logic                   revert_valid,
  input  logic [TagW-1:0]        revert_speculated_dest_phys_reg_tag,
  input  logic                   save_checkpoint_valid,
  input  logic [ROB_INDEX_W-1:0] save_checkpoint_ROB_index,
  output logic                   save_checkpoint_success,
  output logic [ColW-1:0]        save_checkpoint_safe_column,
  input  logic                   restore_checkpoint_valid,
  input  logic                   restore_checkpoint_speculate_failed,
  input  logic [ROB_INDEX_W-1:0] restore_checkpoint_ROB_index,
  input  logic [ColW-1:0]        restore_checkpoint_safe_column,
  output logic                   restore_checkpoint_success,
  output logic [PtrW-1:0]        free_count
);

  logic [TagW-1:0]        entry_q [DEPTH];
  logic [PtrW-1:0]        head_q, head_d;
  logic [PtrW-1:0]        tail_q, tail_d;
  logic [ColW-1:0]        working_q, working_d;
  logic [CHECKPOINT_COLUMNS-1:0] col_valid_q, col_valid_d;
  logic [ROB_INDEX_W-1:0] col_rob_q [CHECKPOINT_COLUMNS];
  logic [ROB_INDEX_W-1:0] col_rob_d [CHECKPOINT_COLUMNS];
  logic [PtrW-1:0]        col_snap_q [CHECKPOINT_COLUMNS];
  logic [PtrW-1:0]        col_snap_d [CHECKPOINT_COLUMNS];

  logic            empty, full;
  logic [ColW-1:0] next_col;
  logic            rev_we, enq_we;

  assign empty    = (head_q == tail_q);
  assign full     = (head_q[IdxW-1:0] == tail_q[IdxW-1:0]) && (head_q[IdxW] != tail_q[IdxW]);
  assign next_col = (working_q == ColW'(CHECKPOINT_COLUMNS - 1)) ? '0 : working_q + ColW'(1);

  assign free_count                  = tail_q - head_q;
  assign dequeue_phys_reg_tag        = entry_q[head_q[IdxW-1:0]];
  assign save_checkpoint_safe_column = working_q;
  assign dequeue_ready = ~empty & ~revert_valid & ~restore_checkpoint_valid &
                         ~save_checkpoint_valid;
  assign enq_we        = enqueue_valid & ~full;

  // Prioritised control events (revert > restore > save > dequeue); enqueue is independent.
  always_comb begin
    head_d                     = head_q;
    tail_d                     = tail_q;
    working_d                  = working_q;
    col_valid_d                = col_valid_q;
    col_rob_d                  = col_rob_q;
    col_snap_d                 = col_snap_q;
    rev_we                     = 1'b0;
    save_checkpoint_success    = 1'b0;
    restore_checkpoint_success = 1'b0;

    if (revert_valid) begin
      if (!full) begin
        head_d = head_q - PtrW'(1);
        rev_we = 1'b1;
        for (int c = 0; c < int'(CHECKPOINT_COLUMNS); c++) begin
          if (c != int'(working_q)) col_valid_d[c] = 1'b0;
        end
      end
    end else if (restore_checkpoint_valid) begin
      if (restore_checkpoint_speculate_failed) begin
        // Only the youngest checkpoint (the working column) can be the mispredicted branch.
        if (col_valid_q[working_q] &&
            (col_rob_q[working_q] == restore_checkpoint_ROB_index)) begin
          restore_checkpoint_success = 1'b1;
          head_d    = col_snap_q[restore_checkpoint_safe_column];
          working_d = restore_checkpoint_safe_column;
          for (int c = 0; c < int'(CHECKPOINT_COLUMNS); c++) begin
            if (c != int'(restore_checkpoint_safe_column)) col_valid_d[c] = 1'b0;
          end
        end
      end else begin
        restore_checkpoint_success                  = 1'b1;
        col_valid_d[restore_checkpoint_safe_column] = 1'b0;
      end
    end else if (save_checkpoint_valid) begin
      if (!col_valid_q[next_col]) begin
        save_checkpoint_success = 1'b1;
        col_snap_d[working_q]   = head_q;
        col_valid_d[next_col]   = 1'b1;
        col_rob_d[next_col]     = save_checkpoint_ROB_index;
        working_d               = next_col;
      end
    end else if (dequeue_valid && dequeue_ready) begin
      head_d = head_q + PtrW'(1);
    end

    if (enq_we) tail_d = tail_q + PtrW'(1);
  end

  // Pointer and checkpoint state; reset leaves the list full and column 0 live.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q      <= '0;
      tail_q      <= PtrW'(DEPTH);
      working_q   <= '0;
      col_valid_q <= CHECKPOINT_COLUMNS'(1);
      for (int c = 0; c < int'(CHECKPOINT_COLUMNS); c++) begin
        col_rob_q[c]  <= '0;
        col_snap_q[c] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      working_q   <= working_d;
      col_valid_q <= col_valid_d;
      col_rob_q   <= col_rob_d;
      col_snap_q  <= col_snap_d;
    end
  end

  // Tag storage; a revert writes below the head, an enqueue writes at the tail.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= TagW'(int'(NUM_ARCH_REGS) + i);
      end
    end else begin
      if (rev_we) entry_q[head_d[IdxW-1:0]] <= revert_speculated_dest_phys_reg_tag;
      if (enq_we) entry_q[tail_q[IdxW-1:0]] <= enqueue_phys_reg_tag;
    end
  end

  // Reverting into a full list or enqueuing into a full list is a protocol error.
  revert_full_chk: assert property (@(posedge CLK) disable iff (!nRST) !(revert_valid && full));
  enqueue_full_chk: assert property (@(posedge CLK) disable iff (!nRST) !(enqueue_valid && full));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: the driver queues the expected
// outputs of each cycle, the monitor pops and compares them at negedge.
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       dequeue_valid = 1'b0;
  logic       dequeue_ready;
  logic [5:0] dequeue_phys_reg_tag;
  logic       enqueue_valid = 1'b0;
  logic [5:0] enqueue_phys_reg_tag = '0;
  logic       revert_valid = 1'b0;
  logic [5:0] revert_tag = '0;
  logic       save_valid = 1'b0;
  logic [5:0] save_rob = '0;
  logic       save_success;
  logic [1:0] safe_col_o;
  logic       restore_valid = 1'b0;
  logic       restore_failed = 1'b0;
  logic [5:0] restore_rob = '0;
  logic [1:0] restore_col = '0;
  logic       restore_success;
  logic [5:0] free_count;

  phys_reg_free_list dut (
    .CLK                                 (CLK),
    .nRST                                (nRST),
    .dequeue_valid                       (dequeue_valid),
    .dequeue_ready                       (dequeue_ready),
    .dequeue_phys_reg_tag                (dequeue_phys_reg_tag),
    .enqueue_valid                       (enqueue_valid),
    .enqueue_phys_reg_tag                (enqueue_phys_reg_tag),
    .revert_valid                        (revert_valid),
    .revert_speculated_dest_phys_reg_tag (revert_tag),
    .save_checkpoint_valid               (save_valid),
    .save_checkpoint_ROB_index           (save_rob),
    .save_checkpoint_success             (save_success),
    .save_checkpoint_safe_column         (safe_col_o),
    .restore_checkpoint_valid            (restore_valid),
    .restore_checkpoint_speculate_failed (restore_failed),
    .restore_checkpoint_ROB_index        (restore_rob),
    .restore_checkpoint_safe_column      (restore_col),
    .restore_checkpoint_success          (restore_success),
    .free_count                          (free_count)
  );

  always #5 CLK = ~CLK;

  localparam logic [5:0] MR = 6'd1, MT = 6'd2, MF = 6'd4, MS = 6'd8, MRS = 6'd16, MC = 6'd32;
  localparam logic [5:0] MALL = 6'd63;

  typedef struct {
    string      name;
    logic [5:0] m;
    logic       rdy;
    logic [5:0] tag;
    logic [5:0] fc;
    logic       ss;
    logic       rs;
    logic [1:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.m[0]) chk({e.name, "_rdy"}, int'(dequeue_ready), int'(e.rdy));
        if (e.m[1]) chk({e.name, "_tag"}, int'(dequeue_phys_reg_tag), int'(e.tag));
        if (e.m[2]) chk({e.name, "_fc"}, int'(free_count), int'(e.fc));
        if (e.m[3]) chk({e.name, "_ss"}, int'(save_success), int'(e.ss));
        if (e.m[4]) chk({e.name, "_rs"}, int'(restore_success), int'(e.rs));
        if (e.m[5]) chk({e.name, "_sc"}, int'(safe_col_o), int'(e.sc));
      end
    end
  end

  task automatic clear_inputs();
    dequeue_valid  = 1'b0;
    enqueue_valid  = 1'b0;
    revert_valid   = 1'b0;
    save_valid     = 1'b0;
    restore_valid  = 1'b0;
    restore_failed = 1'b0;
  endtask

  task automatic step(string n, logic [5:0] m, logic rdy, logic [5:0] tag, logic [5:0] fc,
                      logic ss, logic rs, logic [1:0] sc);
    exp_t e;
    e.name = n; e.m = m; e.rdy = rdy; e.tag = tag; e.fc = fc; e.ss = ss; e.rs = rs; e.sc = sc;
    q.push_back(e);
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step("rst", MALL, 1'b1, 6'd32, 6'd32, 1'b0, 1'b0, 2'd0);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    step("reset", MALL, 1'b1, 6'd32, 6'd32, 1'b0, 1'b0, 2'd0);

    // Drain: tags 32..63 in order, then empty.
    for (int k = 0; k < 32; k++) begin
      dequeue_valid = 1'b1;
      step("drain", MR | MT | MF, 1'b1, 6'(32 + k), 6'(32 - k), 1'b0, 1'b0, 2'd0);
    end
    dequeue_valid = 1'b1;
    step("drain_empty", MR | MF, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);

    // No bypass: enqueue while empty keeps ready low until the next cycle.
    enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd5; dequeue_valid = 1'b1;
    step("nobypass", MR | MF, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    dequeue_valid = 1'b1;
    step("enq5_deq", MR | MT | MF, 1'b1, 6'd5, 6'd1, 1'b0, 1'b0, 2'd0);
    // Walk tail around to the wrap point.
    for (int k = 0; k < 31; k++) begin
      enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'(10 + k); dequeue_valid = 1'b1;
      step("walk_enq", MR | MF, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
      dequeue_valid = 1'b1;
      step("walk_deq", MR | MT | MF, 1'b1, 6'(10 + k), 6'd1, 1'b0, 1'b0, 2'd0);
    end
    enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd21;
    step("wrap_enq0", MR | MF, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd22;
    step("wrap_enq1", MR | MT | MF, 1'b1, 6'd21, 6'd1, 1'b0, 1'b0, 2'd0);
    dequeue_valid = 1'b1;
    step("wrap_deq0", MR | MT | MF, 1'b1, 6'd21, 6'd2, 1'b0, 1'b0, 2'd0);
    dequeue_valid = 1'b1;
    step("wrap_deq1", MR | MT | MF, 1'b1, 6'd22, 6'd1, 1'b0, 1'b0, 2'd0);
    step("wrap_empty", MR | MF, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);

    // Revert: dequeue up to 41, push 41 then 40 back.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      dequeue_valid = 1'b1;
      step("rv_deq", MT | MF, 1'b1, 6'(32 + k), 6'(32 - k), 1'b0, 1'b0, 2'd0);
    end
    revert_valid = 1'b1; revert_tag = 6'd41;
    step("rv_41", MR | MF, 1'b0, 6'd0, 6'd22, 1'b0, 1'b0, 2'd0);
    revert_valid = 1'b1; revert_tag = 6'd40;
    step("rv_40", MR | MF, 1'b0, 6'd0, 6'd23, 1'b0, 1'b0, 2'd0);
    dequeue_valid = 1'b1;
    step("rv_redeq", MR | MT | MF, 1'b1, 6'd40, 6'd24, 1'b0, 1'b0, 2'd0);
    step("rv_next", MT | MF, 1'b1, 6'd41, 6'd23, 1'b0, 1'b0, 2'd0);

    // Save at head 3, dequeue 4, mispredict back to head 3.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      dequeue_valid = 1'b1;
      step("sv_pre", MT, 1'b1, 6'(32 + k), 6'd0, 1'b0, 1'b0, 2'd0);
    end
    save_valid = 1'b1; save_rob = 6'd7; dequeue_valid = 1'b1;
    step("save7", MR | MS | MC | MF, 1'b0, 6'd0, 6'd29, 1'b1, 1'b0, 2'd0);
    step("save7_col", MC | MT, 1'b1, 6'd35, 6'd0, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 4; k++) begin
      dequeue_valid = 1'b1;
      step("sv_deq", MT | MF, 1'b1, 6'(35 + k), 6'(29 - k), 1'b0, 1'b0, 2'd0);
    end
    restore_valid = 1'b1; restore_failed = 1'b1; restore_rob = 6'd7; restore_col = 2'd0;
    step("restore7", MR | MRS | MF, 1'b0, 6'd0, 6'd25, 1'b0, 1'b1, 2'd0);
    step("restore7_st", MT | MF | MC, 1'b1, 6'd35, 6'd29, 1'b0, 1'b0, 2'd0);
    restore_valid = 1'b1; restore_failed = 1'b1; restore_rob = 6'd9; restore_col = 2'd0;
    step("restore9", MRS, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    step("restore9_st", MT | MF | MC, 1'b1, 6'd35, 6'd29, 1'b0, 1'b0, 2'd0);

    // Exhaust checkpoints, release column 0, save again.
    for (int k = 0; k < 3; k++) begin
      save_valid = 1'b1; save_rob = 6'(1 + k);
      step("exh_save", MS | MC, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'(k));
    end
    save_valid = 1'b1; save_rob = 6'd4;
    step("exh_full", MS | MC, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd3);
    restore_valid = 1'b1; restore_failed = 1'b0; restore_col = 2'd0;
    step("release0", MRS | MR, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0);
    save_valid = 1'b1; save_rob = 6'd5;
    step("save_after", MS | MC, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'd3);
    step("save_after_st", MC | MT | MF, 1'b1, 6'd35, 6'd29, 1'b0, 1'b0, 2'd0);

    // Revert wins over save and dequeue; it also frees columns 1..3.
    revert_valid = 1'b1; revert_tag = 6'd50; save_valid = 1'b1; save_rob = 6'd8;
    dequeue_valid = 1'b1;
    step("sim_rv", MR | MS | MF, 1'b0, 6'd0, 6'd29, 1'b0, 1'b0, 2'd0);
    step("sim_rv_st", MT | MF | MC, 1'b1, 6'd50, 6'd30, 1'b0, 1'b0, 2'd0);
    save_valid = 1'b1; save_rob = 6'd6;
    step("sim_save6", MS | MC, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'd0);
    restore_valid = 1'b1; restore_failed = 1'b1; restore_rob = 6'd6; restore_col = 2'd0;
    enqueue_valid = 1'b1; enqueue_phys_reg_tag = 6'd12;
    step("sim_rst_enq", MRS | MF | MC, 1'b0, 6'd0, 6'd30, 1'b0, 1'b1, 2'd1);
    step("sim_rst_enq_st", MR | MT | MF | MC, 1'b1, 6'd50, 6'd31, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset mid-stream.
    dequeue_valid = 1'b1;
    step("pre_rst", MT, 1'b1, 6'd50, 6'd0, 1'b0, 1'b0, 2'd0);
    nRST = 1'b0; dequeue_valid = 1'b1;
    step("mid_rst", MALL, 1'b1, 6'd32, 6'd32, 1'b0, 1'b0, 2'd0);
    nRST = 1'b1;
    step("post_rst", MALL, 1'b1, 6'd32, 6'd32, 1'b0, 1'b0, 2'd0);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge CLK);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Checkpointed FIFO of unmapped physical register tags that supplies `rename_dest_phys_reg_tag` to `phys_reg_map_table` at dispatch.

- Tags are returned at commit, when the old safe mapping is freed.
- Tags are pushed back on ROB revert.
- On branch save and restore, the head pointer is checkpointed and rewound in lockstep with the map table's checkpoint columns.

## Interface
Parameters:
- NUM_PHYS_REGS, 64, total physical registers.
- NUM_ARCH_REGS, 32, architectural registers; tags 0..NUM_ARCH_REGS-1 are never in the list after reset.
- CHECKPOINT_COLUMNS, 4, checkpoint slots; must match the map table.
- DEPTH, derived, NUM_PHYS_REGS-NUM_ARCH_REGS (32). Pointers are log2(DEPTH)+1 bits, including a wrap bit.

Ports:
- CLK in 1: clock, single domain, all state updates on posedge.
- nRST in 1: asynchronous active-low reset.
- dequeue_valid in 1: rename requests a tag.
- dequeue_ready out 1: a tag is available and dequeue is permitted this cycle.
- dequeue_phys_reg_tag out phys_reg_tag_t: tag at head.
- enqueue_valid in 1: commit frees a tag.
- enqueue_phys_reg_tag in phys_reg_tag_t: freed tag.
- revert_valid in 1: ROB revert of one rename.
- revert_speculated_dest_phys_reg_tag in phys_reg_tag_t: tag returned to the head.
- save_checkpoint_valid in 1: branch checkpoint request.
- save_checkpoint_ROB_index in ROB_index_t: tag for the new column.
- save_checkpoint_success out 1: checkpoint taken.
- save_checkpoint_safe_column out checkpoint_column_t: current working column.
- restore_checkpoint_valid in 1: branch resolve.
- restore_checkpoint_speculate_failed in 1: mispredict.
- restore_checkpoint_ROB_index in ROB_index_t: VTM tag.
- restore_checkpoint_safe_column in checkpoint_column_t: column to restore or release.
- restore_checkpoint_success out 1: restore accepted.
- free_count out log2(DEPTH)+1: equals tail-head.

## Operation
State:
- entry[DEPTH], head, tail, working_column.
- column[CHECKPOINT_COLUMNS] of {valid, ROB_index, head_snapshot}.

Reset:
- entry[i]=NUM_ARCH_REGS+i; head=0; tail=DEPTH (wrap bit set, so the list is full).
- column[0].valid=1; other columns have valid=0; all ROB_index and snapshot fields are 0.
- working_column=0.

Empty and full:
- Empty: head==tail.
- Full: index bits equal and wrap bits differ.

Control events are mutually exclusive in priority order: revert > restore > save > dequeue. Enqueue is independent and may coincide with any of them.

- **Revert:** head-=1 and entry[head-1]=revert tag. Invalidate all columns except working_column. If the list is full, raise an assertion error and leave state unchanged.
- **Restore, speculate_failed=1:** success requires column[working_column].valid and ROB_index==restore_checkpoint_ROB_index. On success:
  - head=column[safe].head_snapshot and working_column=safe.
  - Invalidate every column except safe.
  - restore_checkpoint_success=1.
  - On VTM miss, change no state and drive success=0.
- **Restore, speculate_failed=0:** column[safe].valid=0 and success=1. head is unchanged.
- **Save:** succeeds if column[working_column+1].valid==0; otherwise success=0 and state is unchanged. On success:
  - column[working_column].head_snapshot=head.
  - column[working_column+1] gets valid=1 and ROB_index=save_checkpoint_ROB_index.
  - working_column increments, wrapping modulo CHECKPOINT_COLUMNS.
- **Dequeue:** dequeue_ready = ~empty & ~revert_valid & ~restore_checkpoint_valid & ~save_checkpoint_valid. The dequeue fires when valid & ready, and head+=1.
- **Enqueue:** entry[tail]=tag and tail+=1. Enqueue while full is an assertion error and the tag is dropped. There is no enqueue-to-dequeue bypass: while the list is empty, ready stays 0 even if an enqueue is in progress.
- **Pointer arithmetic:** index bits wrap modulo DEPTH, with the wrap bit toggling on wrap. DEPTH is a power of 2.

## Timing
- All outputs are combinational from state and current inputs.
- Reset values of outputs (with all valid inputs low):
  - dequeue_ready=1, dequeue_phys_reg_tag=32, free_count=32.
  - Both successes=0, save_checkpoint_safe_column=0.
- State updates take effect at the next posedge. A tag enqueued in cycle N is dequeueable in cycle N+1 at the earliest.
- Success outputs are valid in the same cycle as their request. Requesters hold valid until they see success.
- nRST assertion mid-operation returns all state to reset values immediately, regardless of CLK.

## Test plan
- **Drain the list:** after reset, dequeue every cycle for 32 cycles. Tags 32..63 must come out in order. In cycle 33, dequeue_ready=0 and free_count=0.
- **Enqueue/dequeue wrap:** with the list empty, enqueue 5 then hold dequeue_valid. Ready goes 1 the next cycle and 5 is returned. tail wraps from 31 to 0 with the wrap bit toggling, and free_count stays consistent.
- **Revert:** dequeue 40 and 41, then revert 41 followed by revert 40. The next dequeue returns 40, and free_count returns to its pre-dequeue value.
- **Save and mispredict:**
  - Save with ROB_index=7 at head=3: success=1 and safe_column=0.
  - Dequeue 4 tags.
  - Restore with failed=1, ROB_index=7, safe=0: success=1, head=3, and working_column=0.
  - Restore with ROB_index=9: success=0 and state is unchanged.
- **Checkpoint exhaustion and release:** 3 saves succeed, and the 4th returns success=0. A restore with failed=0 on column 0 frees a slot, after which the next save succeeds.
- **Simultaneous events:** revert together with save and dequeue_valid gives only the revert and dequeue_ready=0. Enqueue concurrent with a restore still updates tail. Asserting nRST mid-stream resets to full with tag 32 at the head.
